// File: rtl/iob_nco_multi.sv
// Multi-channel fractional NCO clock generator with double-buffered period/duty config.
// Optional macro IOB_NCO_MULTI_DUTY_EN adds cfg_duty_i and per-channel programmable high time.
module iob_nco_multi #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int PERIOD_W = DATA_W + FRAC_W,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                rst_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
`ifdef IOB_NCO_MULTI_DUTY_EN
  input  logic [DATA_W-1:0]   cfg_duty_i,
`endif
  input  logic                cfg_wen_i,
  input  logic                commit_i,
  input  logic                resync_i,
  input  logic [N_CH-1:0]     en_i,
  output logic [N_CH-1:0]     pending_o,
  output logic [N_CH-1:0]     tick_o,
  output logic [N_CH-1:0]     clk_out_o,
  output logic [N_CH-1:0]     dbg_run_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [DATA_W:0] ONE = (DATA_W+1)'(1);
  localparam logic [DATA_W:0] TWO = (DATA_W+1)'(2);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t                r_state;
    logic [PERIOD_W-1:0]   r_sh_period;
    logic [PERIOD_W-1:0]   r_act_period;
    logic                  r_pending;
    logic                  r_tick;
    logic                  r_clk;
    logic [DATA_W:0]       r_cnt;
    logic [DATA_W:0]       r_len;
    logic [DATA_W:0]       r_high;
    logic [FRAC_W-1:0]     r_res;

    logic                  w_wr;
    logic                  w_apply;
    logic                  w_start;
    logic                  w_copy;
    logic                  w_carry;
    logic [PERIOD_W-1:0]   w_period;
    logic [DATA_W-1:0]     w_p_int;
    logic [FRAC_W-1:0]     w_res_base;
    logic [FRAC_W-1:0]     w_res_next;
    logic [DATA_W:0]       w_p_eff;
    logic [DATA_W:0]       w_len;
    logic [DATA_W:0]       w_high;
    logic [DATA_W:0]       w_cnt_next;

    assign w_wr    = cfg_wen_i && (cfg_ch_i == CH_W'(c));
    // A commit landing on a period start defers the transfer to the following start.
    assign w_apply = r_pending && !commit_i;
    assign w_start = en_i[c] && ((r_state == ST_IDLE) || resync_i || (r_cnt == r_len - ONE));
    assign w_copy  = w_apply && (w_start || (r_state == ST_IDLE));

    // Parameters of the period about to start, taken from shadow if it transfers now.
    assign w_period   = w_apply ? r_sh_period : r_act_period;
    assign w_p_int    = w_period[PERIOD_W-1:FRAC_W];
    assign w_p_eff    = (w_p_int < DATA_W'(2)) ? TWO : {1'b0, w_p_int};
    assign w_res_base = ((r_state == ST_IDLE) || resync_i) ? '0 : r_res;
    assign {w_carry, w_res_next} = {1'b0, w_res_base} + {1'b0, w_period[FRAC_W-1:0]};
    assign w_len      = w_p_eff + {{DATA_W{1'b0}}, w_carry};
    assign w_cnt_next = r_cnt + ONE;

`ifdef IOB_NCO_MULTI_DUTY_EN
    logic [DATA_W-1:0] r_sh_duty;
    logic [DATA_W-1:0] r_act_duty;
    logic [DATA_W-1:0] w_duty;

    assign w_duty = w_apply ? r_sh_duty : r_act_duty;
    assign w_high = ({1'b0, w_duty} >= w_len) ? (w_len - ONE) : {1'b0, w_duty};

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        r_sh_duty  <= '0;
        r_act_duty <= '0;
      end else if (rst_i) begin
        r_sh_duty  <= '0;
        r_act_duty <= '0;
      end else if (cke_i) begin
        if (w_wr)   r_sh_duty  <= cfg_duty_i;
        if (w_copy) r_act_duty <= r_sh_duty;
      end
    end
`else
    assign w_high = {1'b0, w_len[DATA_W:1]};
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        r_state      <= ST_IDLE;
        r_sh_period  <= '0;
        r_act_period <= '0;
        r_pending    <= 1'b0;
        r_tick       <= 1'b0;
        r_clk        <= 1'b0;
        r_cnt        <= '0;
        r_len        <= '0;
        r_high       <= '0;
        r_res        <= '0;
      end else if (rst_i) begin
        r_state      <= ST_IDLE;
        r_sh_period  <= '0;
        r_act_period <= '0;
        r_pending    <= 1'b0;
        r_tick       <= 1'b0;
        r_clk        <= 1'b0;
        r_cnt        <= '0;
        r_len        <= '0;
        r_high       <= '0;
        r_res        <= '0;
      end else if (cke_i) begin
        if (w_wr)   r_sh_period  <= cfg_period_i;
        if (w_copy) r_act_period <= r_sh_period;

        if (commit_i)    r_pending <= 1'b1;
        else if (w_copy) r_pending <= 1'b0;

        if (!en_i[c]) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_res   <= '0;
          r_tick  <= 1'b0;
          r_clk   <= 1'b0;
        end else if (w_start) begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
          r_res   <= w_res_next;
          r_len   <= w_len;
          r_high  <= w_high;
          r_tick  <= 1'b1;
          r_clk   <= (w_high != '0);
        end else begin
          r_cnt   <= w_cnt_next;
          r_tick  <= 1'b0;
          r_clk   <= (w_cnt_next < r_high);
        end
      end
    end

    assign pending_o[c] = r_pending;
    assign tick_o[c]    = r_tick;
    assign clk_out_o[c] = r_clk;
    assign dbg_run_o[c] = (r_state == ST_RUN);
  end

endmodule

// File: tb/tb_iob_nco_multi.sv
// Bench for iob_nco_multi: vector table, directed corner sequences, and randomized
// traffic checked every cycle against an accumulated-phase reference model.
module tb_iob_nco_multi;
  localparam int N_CH     = 4;
  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int PERIOD_W = DATA_W + FRAC_W;
  localparam int CH_W     = 2;
`ifdef IOB_NCO_MULTI_DUTY_EN
  localparam bit DUTY_MODE = 1'b1;
`else
  localparam bit DUTY_MODE = 1'b0;
`endif

  // clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                cke_i = 1'b1;
  logic                arst_n_i = 1'b0;
  logic                rst_i = 1'b0;
  logic [CH_W-1:0]     cfg_ch_i = '0;
  logic [PERIOD_W-1:0] cfg_period_i = '0;
  logic [DATA_W-1:0]   cfg_duty_i = '0;
  logic                cfg_wen_i = 1'b0;
  logic                commit_i = 1'b0;
  logic                resync_i = 1'b0;
  logic [N_CH-1:0]     en_i = '0;
  logic [N_CH-1:0]     pending_o;
  logic [N_CH-1:0]     tick_o;
  logic [N_CH-1:0]     clk_out_o;
  logic [N_CH-1:0]     dbg_run_o;

  iob_nco_multi #(.N_CH(N_CH), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk_i        (clk_i),
    .cke_i        (cke_i),
    .arst_n_i     (arst_n_i),
    .rst_i        (rst_i),
    .cfg_ch_i     (cfg_ch_i),
    .cfg_period_i (cfg_period_i),
`ifdef IOB_NCO_MULTI_DUTY_EN
    .cfg_duty_i   (cfg_duty_i),
`endif
    .cfg_wen_i    (cfg_wen_i),
    .commit_i     (commit_i),
    .resync_i     (resync_i),
    .en_i         (en_i),
    .pending_o    (pending_o),
    .tick_o       (tick_o),
    .clk_out_o    (clk_out_o),
    .dbg_run_o    (dbg_run_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a period starts at absolute cycle floor(sum_of_words / 2^FRAC_W)
  int     m_sh[N_CH], m_act[N_CH], m_shd[N_CH], m_actd[N_CH];
  bit     m_pend[N_CH], m_run[N_CH];
  longint m_acc[N_CH], m_abs[N_CH], m_start[N_CH], m_next[N_CH], m_high[N_CH];
  logic [15:0] exp_q[$];

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_sh[c] = 0; m_act[c] = 0; m_shd[c] = 0; m_actd[c] = 0;
      m_pend[c] = 0; m_run[c] = 0;
      m_acc[c] = 0; m_abs[c] = 0; m_start[c] = 0; m_next[c] = 0; m_high[c] = 0;
    end
  endfunction

  function automatic logic [15:0] model_expect();
    logic [3:0] p, t, k, r;
    for (int c = 0; c < N_CH; c++) begin
      p[c] = m_pend[c];
      r[c] = m_run[c];
      t[c] = m_run[c] && (m_abs[c] == m_start[c]);
      k[c] = m_run[c] && ((m_abs[c] - m_start[c]) < m_high[c]);
    end
    return {p, t, k, r};
  endfunction

  function automatic void model_step();
    int cur_duty;
    cur_duty = DUTY_MODE ? int'(cfg_duty_i) : 0;
    if (rst_i) model_reset();
    else if (cke_i) begin
      for (int c = 0; c < N_CH; c++) begin
        bit was_run, apply, bnd, start;
        longint ip, len;
        was_run = m_run[c];
        apply   = m_pend[c] && !commit_i;
        bnd     = was_run && (m_abs[c] + 1 == m_next[c]);
        start   = en_i[c] && (!was_run || resync_i || bnd);
        if (apply && (start || !was_run)) begin
          m_act[c]  = m_sh[c];
          m_actd[c] = m_shd[c];
          m_pend[c] = 0;
        end
        if (commit_i) m_pend[c] = 1;
        if (!en_i[c]) m_run[c] = 0;
        else if (start) begin
          if (!was_run || resync_i) begin
            m_acc[c] = 0;
            m_abs[c] = 0;
          end else m_abs[c]++;
          ip = longint'(m_act[c] / 256);
          if (ip < 2) ip = 2;
          m_start[c] = m_abs[c];
          m_acc[c]  += ip * 256 + longint'(m_act[c] % 256);
          m_next[c]  = m_acc[c] / 256;
          len        = m_next[c] - m_start[c];
          if (DUTY_MODE) m_high[c] = (m_actd[c] >= len) ? len - 1 : longint'(m_actd[c]);
          else           m_high[c] = len / 2;
          m_run[c] = 1;
        end else m_abs[c]++;
        if (cfg_wen_i && int'(cfg_ch_i) == c) begin
          m_sh[c]  = int'(cfg_period_i);
          m_shd[c] = cur_duty;
        end
      end
    end
    exp_q.push_back(model_expect());
  endfunction

  // scoreboard
  task automatic check_outputs();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
      return;
    end
    e = exp_q.pop_front();
    chk("pending", int'(pending_o), int'(e[15:12]));
    chk("tick",    int'(tick_o),    int'(e[11:8]));
    chk("clk_out", int'(clk_out_o), int'(e[7:4]));
    chk("dbg_run", int'(dbg_run_o), int'(e[3:0]));
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle_inputs();
    cfg_wen_i = 1'b0; commit_i = 1'b0; resync_i = 1'b0;
  endtask

  task automatic rst_pulse();
    idle_inputs();
    en_i = '0; cke_i = 1'b1; rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int period, input int duty, input bit commit);
    cfg_ch_i = CH_W'(ch); cfg_period_i = PERIOD_W'(period); cfg_duty_i = DATA_W'(duty);
    cfg_wen_i = 1'b1; commit_i = commit;
    cycle();
    idle_inputs();
  endtask

  task automatic wait_tick(input int ch, input int bound, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick_o[ch] && n < bound);
    if (!tick_o[ch]) begin
      n_checks++; n_errors++;
      $display("FAIL wait_tick_timeout ch%0d after %0d cycles", ch, n);
    end
  endtask

  typedef struct {
    int period;
    int duty;
    int cycles;
    int exp_ticks;
    int exp_high;
  } vec_t;

  vec_t tbl[10];
  int   n_vec;

  initial begin
    int nt, nh, n, co;

    // period word, duty, window, ticks in window, high cycles in window
    tbl[0] = '{32'h000400, 2, 20,  5, 10};
    tbl[1] = '{32'h000280, 1, 20,  8,  8};
    tbl[2] = '{32'h000100, 1, 20, 10, 10};
    tbl[3] = '{32'h000000, 1, 20, 10, 10};
    tbl[4] = '{32'h000A00, 5, 20,  2, 10};
    tbl[5] = '{32'h0001FF, 1, 20,  7,  7};
    tbl[6] = '{32'h000700, 3, 20,  3,  9};
    n_vec = 7;
`ifdef IOB_NCO_MULTI_DUTY_EN
    tbl[7] = '{32'h000500, 1, 20, 4,  4};
    tbl[8] = '{32'h000500, 9, 20, 4, 16};
    tbl[9] = '{32'h000500, 0, 20, 4,  0};
    n_vec = 10;
`endif

    // reset state
    #12;
    chk("rst_clk_out", int'(clk_out_o), 0);
    chk("rst_tick",    int'(tick_o),    0);
    chk("rst_pending", int'(pending_o), 0);
    arst_n_i = 1'b1;
    model_reset();

    // vector table on channel 0
    for (int v = 0; v < n_vec; v++) begin
      rst_pulse();
      write_cfg(0, tbl[v].period, tbl[v].duty, 1'b1);
      en_i = 4'b0001;
      nt = 0; nh = 0;
      for (int i = 0; i < tbl[v].cycles; i++) begin
        cycle();
        if (tick_o[0]) nt++;
        if (clk_out_o[0]) nh++;
      end
      chk($sformatf("tbl%0d_ticks", v), nt, tbl[v].exp_ticks);
      chk($sformatf("tbl%0d_high", v), nh, tbl[v].exp_high);
      en_i = '0;
      cycle();
    end

    // 2.5 on ch1: ten periods span 25 cycles
    rst_pulse();
    write_cfg(1, 32'h000280, 1, 1'b1);
    en_i = 4'b0010;
    cycle();
    chk("frac_first_tick", int'(tick_o[1]), 1);
    nt = 0; n = 0;
    while (nt < 10 && n < 100) begin
      cycle();
      n++;
      if (tick_o[1]) nt++;
    end
    chk("frac_span", n, 25);

    // commit mid-period: 10.0 period completes, then 6.0
    rst_pulse();
    write_cfg(0, 32'h000A00, 5, 1'b1);
    en_i = 4'b0001;
    cycle();
    repeat (3) cycle();
    write_cfg(0, 32'h000600, 3, 1'b1);
    chk("pend_held", int'(pending_o[0]), 1);
    wait_tick(0, 20, n);
    chk("old_tail", n, 6);
    chk("pend_cleared", int'(pending_o[0]), 0);
    wait_tick(0, 20, n);
    chk("new_len", n, 6);

    // same-cycle enable: ch0=3.0, ch1=6.0 aligned, then resync mid-period
    rst_pulse();
    write_cfg(0, 32'h000300, 1, 1'b0);
    write_cfg(1, 32'h000600, 3, 1'b1);
    en_i = 4'b0011;
    co = 0;
    for (int i = 0; i < 18; i++) begin
      cycle();
      if (tick_o[1] && tick_o[0]) co++;
    end
    chk("aligned", co, 3);
    repeat (2) cycle();
    resync_i = 1'b1;
    cycle();
    resync_i = 1'b0;
    chk("resync_ticks", int'(tick_o[1:0]), 3);
    wait_tick(1, 20, n);
    chk("post_resync_len", n, 6);
    chk("post_resync_align", int'(tick_o[0]), 1);

    // divide-by-2 with async reset mid-run
    rst_pulse();
    write_cfg(2, 32'h000100, 1, 1'b1);
    en_i = 4'b0100;
    repeat (5) cycle();
    #2 arst_n_i = 1'b0;
    #1;
    chk("arst_clk_out", int'(clk_out_o), 0);
    chk("arst_tick",    int'(tick_o),    0);
    chk("arst_pending", int'(pending_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("arst_hold_clk", int'(clk_out_o), 0);
    #2 arst_n_i = 1'b1;
    model_reset();
    cycle();
    chk("post_arst_tick", int'(tick_o[2]), 1);
    cycle();
    chk("post_arst_low", int'(clk_out_o[2]), 0);
    cycle();
    chk("post_arst_tick2", int'(tick_o[2]), 1);

    // clock-enable freeze, including a commit that must not land
    cke_i = 1'b0; commit_i = 1'b1;
    repeat (3) cycle();
    chk("cke_pending", int'(pending_o), 0);
    commit_i = 1'b0; cke_i = 1'b1;
    repeat (3) cycle();

    // randomized traffic against the model
    rst_pulse();
    for (int i = 0; i < 4000; i++) begin
      cke_i     = ($urandom_range(0, 9) != 0);
      rst_i     = ($urandom_range(0, 799) == 0);
      cfg_wen_i = ($urandom_range(0, 2) == 0);
      cfg_ch_i  = CH_W'($urandom_range(0, N_CH-1));
      cfg_period_i = PERIOD_W'(($urandom_range(0, 9) << FRAC_W) |
                               (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 255)));
      cfg_duty_i = DATA_W'($urandom_range(0, 12));
      commit_i  = ($urandom_range(0, 7) == 0);
      resync_i  = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 29) == 0) en_i[c] = ~en_i[c];
      cycle();
    end
    idle_inputs();
    rst_i = 1'b0;
    cke_i = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
